// File: rtl/cache_pkg.sv
// Shared cache geometry, refill FSM state type and line/beat helpers used by
// the refill unit and its memory-bus interface.
package cache_pkg;

    localparam int ADDRESS_WIDTH   = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int LINE_SIZE_BYTES = 64;
    localparam int OFFSET_BITS     = 6;
    localparam int INDEX_BITS      = 6;
    localparam int TAG_BITS        = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int LINE_SIZE_BITS  = LINE_SIZE_BYTES * 8;
    localparam int BEATS           = LINE_SIZE_BITS / DATA_WIDTH;
    localparam int BEAT_BITS       = $clog2(BEATS);
    localparam int WORD_BYTE_BITS  = $clog2(DATA_WIDTH / 8);

    typedef logic [ADDRESS_WIDTH-1:0]  addr_t;
    typedef logic [DATA_WIDTH-1:0]     data_t;
    typedef logic [LINE_SIZE_BITS-1:0] line_t;
    typedef logic [BEAT_BITS-1:0]      beat_idx_t;

    localparam addr_t LINE_MASK = ~addr_t'(LINE_SIZE_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_RD,
        ST_RESP,
        ST_DRAIN
    } refill_state_t;

    // The base is line aligned, so OR-ing in the word offset can never carry
    // into the index/tag bits.
    function automatic addr_t beat_addr(input addr_t base, input beat_idx_t beat);
        return base | addr_t'({beat, {WORD_BYTE_BITS{1'b0}}});
    endfunction

    function automatic data_t line_word(input line_t line, input beat_idx_t beat);
        return line[int'(beat)*DATA_WIDTH +: DATA_WIDTH];
    endfunction

endpackage

// File: rtl/cache_refill_unit_if.sv
// Word-wide main-memory beat bus between the refill unit (master) and memory.
interface cache_refill_unit_if;
    import cache_pkg::*;

    logic  req;
    logic  we;
    addr_t addr;
    data_t wdata;
    logic  ready;
    data_t rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );

endinterface

// File: rtl/cache_refill_unit_beat_counter.sv
// Beat index counter shared by the write-back and read phases of a refill.
module beat_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] LAST  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    // Clear wins over enable so a phase change always restarts at beat 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == LAST);

endmodule

// File: rtl/cache_refill_unit.sv
// Cache miss handler: writes back a dirty victim, fetches the missing line one
// word per beat, and returns the assembled line with a one-cycle pulse.
module cache_refill_unit
    import cache_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       miss,
    input  addr_t                      miss_addr,
    input  logic                       evict,
    input  addr_t                      evict_addr,
    input  line_t                      evict_line,
    output line_t                      fill_line,
    output logic                       fill_valid,
    output logic                       busy,
    cache_refill_unit_if.master        mem
);

    refill_state_t state;
    addr_t         miss_base;
    addr_t         evict_base;
    line_t         victim;
    line_t         fill_q;
    logic          fill_valid_q;
    logic          busy_q;
    logic          req_q;
    logic          we_q;
    addr_t         addr_q;
    data_t         wdata_q;

    beat_idx_t     beat;
    beat_idx_t     next_beat;
    logic          last_beat;
    logic          beat_accept;
    logic          wb_done;
    logic          cnt_clear;

    assign next_beat   = beat + 1'b1;
    assign beat_accept = req_q & mem.ready;
    assign wb_done     = (state == ST_WB) & beat_accept & last_beat;
    assign cnt_clear   = (state == ST_IDLE) | wb_done;

    beat_counter #(
        .WIDTH (BEAT_BITS),
        .LAST  (beat_idx_t'(BEATS - 1))
    ) u_beat_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (beat_accept),
        .count  (beat),
        .last   (last_beat)
    );

    // Outputs are precomputed for the next beat so the bus is registered and
    // still presents back-to-back beats when ready stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            miss_base    <= '0;
            evict_base   <= '0;
            victim       <= '0;
            fill_q       <= '0;
            fill_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            fill_valid_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (miss) begin
                        miss_base  <= miss_addr & LINE_MASK;
                        evict_base <= evict_addr & LINE_MASK;
                        victim     <= evict_line;
                        busy_q     <= 1'b1;
                        req_q      <= 1'b1;
                        if (evict) begin
                            state   <= ST_WB;
                            we_q    <= 1'b1;
                            addr_q  <= beat_addr(evict_addr & LINE_MASK, '0);
                            wdata_q <= line_word(evict_line, '0);
                        end else begin
                            state   <= ST_RD;
                            we_q    <= 1'b0;
                            addr_q  <= beat_addr(miss_addr & LINE_MASK, '0);
                            wdata_q <= '0;
                        end
                    end
                end

                ST_WB: begin
                    if (mem.ready) begin
                        if (last_beat) begin
                            state   <= ST_RD;
                            we_q    <= 1'b0;
                            addr_q  <= beat_addr(miss_base, '0);
                            wdata_q <= '0;
                        end else begin
                            addr_q  <= beat_addr(evict_base, next_beat);
                            wdata_q <= line_word(victim, next_beat);
                        end
                    end
                end

                ST_RD: begin
                    if (mem.ready) begin
                        fill_q[int'(beat)*DATA_WIDTH +: DATA_WIDTH] <= mem.rdata;
                        if (last_beat) begin
                            state  <= ST_RESP;
                            req_q  <= 1'b0;
                            addr_q <= '0;
                        end else begin
                            addr_q <= beat_addr(miss_base, next_beat);
                        end
                    end
                end

                ST_RESP: begin
                    fill_valid_q <= 1'b1;
                    state        <= ST_DRAIN;
                end

                // A level miss still held after the response must not start
                // a second refill of the same line.
                ST_DRAIN: begin
                    if (!miss) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    req_q  <= 1'b0;
                    we_q   <= 1'b0;
                end
            endcase
        end
    end

    assign fill_line  = fill_q;
    assign fill_valid = fill_valid_q;
    assign busy       = busy_q;
    assign mem.req    = req_q;
    assign mem.we     = we_q;
    assign mem.addr   = addr_q;
    assign mem.wdata  = wdata_q;

endmodule

// File: doc/cache_refill_unit.md
Name: cache_refill_unit

Overview:
- Miss-handling stage directly downstream of the 4-way set-associative cache.
- On a cache miss it writes back a dirty victim line, then fetches the missing line from main memory one word per beat.
- It assembles the words into a full line and returns it to the cache with a single-cycle response pulse.
- It sits between the cache's miss/evict outputs and the word-wide main-memory bus.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, memory bus word width in bits.
- LINE_SIZE_BYTES, 64, cache line size in bytes.
- OFFSET_BITS, 6, log2(LINE_SIZE_BYTES).
- BEATS, LINE_SIZE_BYTES*8/DATA_WIDTH (16), derived localparam; words per line.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_miss  in  1  cache miss request, level; held until the response is consumed.
- i_miss_addr  in  ADDRESS_WIDTH  missing byte address; offset bits are ignored.
- i_evict  in  1  victim line is valid and dirty; sampled together with i_miss.
- i_evict_addr  in  ADDRESS_WIDTH  victim line address; offset bits are ignored.
- i_evict_line  in  LINE_SIZE_BYTES*8  victim line data.
- o_fill_line  out  LINE_SIZE_BYTES*8  assembled line; drives the cache's i_memory_line.
- o_fill_valid  out  1  one-cycle pulse; drives the cache's i_memory_response.
- o_busy  out  1  high in every state except IDLE.
- o_mem_req  out  1  memory beat request.
- o_mem_we  out  1  1 = write beat, 0 = read beat.
- o_mem_addr  out  ADDRESS_WIDTH  word-aligned beat address.
- o_mem_wdata  out  DATA_WIDTH  write data.
- i_mem_ready  in  1  beat accepted; for reads, i_mem_rdata is valid in the same cycle.
- i_mem_rdata  in  DATA_WIDTH  read data.

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE, beat counter = 0, all outputs 0, fill buffer cleared.
- Reset mid-operation discards any partial transfer. Memory must tolerate a dropped o_mem_req.

States:
- IDLE: when i_miss = 1, latch the line-aligned i_miss_addr (offset zeroed), i_evict, i_evict_addr and i_evict_line, and clear the counter. Go to WB if i_evict, else to RD.
- WB: o_mem_req = 1, o_mem_we = 1, o_mem_addr = evict base + 4*beat, o_mem_wdata = victim word [beat*DATA_WIDTH +: DATA_WIDTH]. Each cycle with i_mem_ready = 1 advances the beat. After beat BEATS-1 is accepted, clear the counter and go to RD.
- RD: o_mem_req = 1, o_mem_we = 0, o_mem_addr = miss base + 4*beat. On i_mem_ready = 1, write i_mem_rdata into fill buffer bits [beat*DATA_WIDTH +: DATA_WIDTH] (word 0 at the LSBs, consistent with the cache's 8*offset indexing). After beat BEATS-1 is accepted, go to RESP.
- RESP: o_fill_valid = 1 for exactly one cycle; o_fill_line is stable from this cycle until the next fill begins. Go to DRAIN.
- DRAIN: wait for i_miss = 0, then go to IDLE. This prevents a stale level miss from retriggering.

Handshake and timing rules:
- o_mem_req stays high, and address/data stay stable, until i_mem_ready. There are no gaps between consecutive beats when ready is continuously high.
- i_mem_ready while o_mem_req = 0 is ignored.
- Beat address arithmetic is modulo 2^ADDRESS_WIDTH; the offset is never carried into the index.
- Latency with ready tied high:
  - Clean miss: i_miss at cycle 0 → o_fill_valid at cycle BEATS+2.
  - Dirty miss: i_miss at cycle 0 → o_fill_valid at cycle 2*BEATS+2.
- Changes to i_miss or i_evict* inputs after capture are ignored until IDLE.
- i_evict = 1 with i_miss = 0 is ignored.

Decomposition:
- Shared package cache_pkg holds:
  - ADDRESS_WIDTH, DATA_WIDTH, LINE_SIZE_BYTES, OFFSET_BITS, TAG_BITS, INDEX_BITS.
  - Derived LINE_SIZE_BITS and BEATS.
  - State enum type refill_state_t.
- One sub-module, beat_counter: width $clog2(BEATS), with clear, enable and a last-beat flag. It is instantiated once and reused for both the WB and RD phases.

Test Plan:
- Clean miss, ready tied high: i_miss = 1, addr 0x0000_1234, i_evict = 0 → 16 reads at 0x1200..0x123C, fill_valid at cycle 18, fill_line word k = read data k.
- Dirty miss: i_evict = 1, evict_addr 0x0008_0040, evict_line word k = 0xA000_0000+k → 16 writes at 0x80040..0x8007C with matching wdata, then 16 reads, then one fill_valid pulse.
- Backpressure: i_mem_ready low 3 cycles before every beat, clean miss → addr/req stable while stalled, exactly 16 accepted beats, fill_valid only after the last one.
- Held miss: i_miss stays high 5 cycles after fill_valid → no new mem_req until i_miss drops; new miss afterwards is served normally.
- Async reset asserted during RD beat 7 → all outputs 0 immediately, state IDLE; next miss restarts at beat 0 with the correct address.
- Address wrap: miss at 0xFFFF_FFC8 → beat addresses 0xFFFF_FFC0..0xFFFF_FFFC, no overflow into other bits.
